// File: rtl/cpu_step_host.sv
// Host side of the CPU halt/continue handshake: captures out words, drives cont.
// Optional: CPU_STEP_TIMEOUT_EN adds a RESUME watchdog with one retry pulse.
module cpu_step_host #(
  parameter int DEPTH        = 8,
  parameter int PULSE_CYCLES = 3,
  parameter int AUTO_DELAY   = 16
`ifdef CPU_STEP_TIMEOUT_EN
  , parameter int TIMEOUT    = 255
`endif
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              cpu_out,
  input  logic                     cpu_halted,
  output logic                     cont,
  input  logic                     auto_mode,
  input  logic                     go,
  input  logic                     rd_en,
  output logic [31:0]              rd_data,
  output logic                     rd_valid,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
`ifdef CPU_STEP_TIMEOUT_EN
  output logic                     timeout_err,
`endif
  output logic                     stalled
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = $clog2(AUTO_DELAY + 1);
  localparam int PW = $clog2(PULSE_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, CAPTURE, HOLD, PULSE, RESUME
  } state_t;

  state_t          state, state_n;
  logic [DW-1:0]   dcnt, dcnt_n;
  logic [PW-1:0]   pcnt, pcnt_n;
  logic [31:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   cnt;
  logic            wr, rd;

`ifdef CPU_STEP_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]   tcnt, tcnt_n;
  logic            retry, retry_n;
  logic            terr, terr_n;
  assign timeout_err = terr;
`endif

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign count   = cnt;
  assign stalled = (state == IDLE) && cpu_halted && full;
  assign wr      = (state == CAPTURE);
  assign rd      = rd_en && !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      dcnt  <= '0;
      pcnt  <= '0;
      cont  <= 1'b0;
`ifdef CPU_STEP_TIMEOUT_EN
      tcnt  <= '0;
      retry <= 1'b0;
      terr  <= 1'b0;
`endif
    end else begin
      state <= state_n;
      dcnt  <= dcnt_n;
      pcnt  <= pcnt_n;
      cont  <= (state == PULSE);
`ifdef CPU_STEP_TIMEOUT_EN
      tcnt  <= tcnt_n;
      retry <= retry_n;
      terr  <= terr_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    dcnt_n  = dcnt;
    pcnt_n  = pcnt;
`ifdef CPU_STEP_TIMEOUT_EN
    tcnt_n  = tcnt;
    retry_n = retry;
    terr_n  = terr;
`endif
    unique case (state)
      IDLE: begin
        if (cpu_halted && !full)
          state_n = CAPTURE;
      end
      CAPTURE: begin
        dcnt_n  = DW'(AUTO_DELAY - 1);
        state_n = HOLD;
      end
      HOLD: begin
        // release on the cycle the counter would step to zero
        if (auto_mode) begin
          if (dcnt <= DW'(1)) begin
            dcnt_n  = '0;
            state_n = PULSE;
          end else begin
            dcnt_n = dcnt - 1'b1;
          end
        end else if (go) begin
          state_n = PULSE;
        end
      end
      PULSE: begin
        if (pcnt == PW'(PULSE_CYCLES - 1)) begin
          pcnt_n  = '0;
          state_n = RESUME;
        end else begin
          pcnt_n = pcnt + 1'b1;
        end
      end
      RESUME: begin
        if (!cpu_halted) begin
          state_n = IDLE;
`ifdef CPU_STEP_TIMEOUT_EN
          tcnt_n  = '0;
          retry_n = 1'b0;
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          tcnt_n = '0;
          terr_n = 1'b1;
          if (retry) begin
            retry_n = 1'b0;
            dcnt_n  = DW'(AUTO_DELAY - 1);
            state_n = HOLD;
          end else begin
            retry_n = 1'b1;
            state_n = PULSE;
          end
        end else begin
          tcnt_n = tcnt + 1'b1;
`endif
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr)
      mem[wr_ptr] <= cpu_out;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd;
      if (wr)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      unique case ({wr, rd})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule
